// File: rtl/asw_scan_pkg.sv
// asw_scan_pkg: shared states, channel count and width helper for the ADG715 channel-scan sequencer
package asw_scan_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT_STOP, SETTLE, PRESENT, NEXT} state_t;
    localparam int CH_PER_DEV = 8;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/asw_cycle_timer.sv
// asw_cycle_timer: loadable down-counter shared by the setup, timeout and settle phases
module asw_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= value;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    assign expired = cnt == '0;
endmodule

// File: rtl/asw_scan_seq.sv
// asw_scan_seq: steps every ADG715 channel through the switch writer, settles, then hands it to acquisition.
// Define ASW_SKIP_MASK_EN to add ch_mask and skip masked channels.
module asw_scan_seq
    import asw_scan_pkg::*;
#(
    parameter int NUM_DEV        = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scan_start,
    input  logic       scan_abort,
    input  logic       continuous,
`ifdef ASW_SKIP_MASK_EN
    input  logic [NUM_DEV*CH_PER_DEV-1:0] ch_mask,
`endif
    output logic       start_flag,
    output logic [1:0] asw_addr,
    output logic [2:0] asw_channel,
    input  logic       stop_flag,
    output logic       ch_valid,
    input  logic       ch_ack,
    output logic       busy,
    output logic       scan_done,
    output logic       timeout_err
);
    localparam int MAXC = TIMEOUT_CYCLES > SETTLE_CYCLES ?
        (TIMEOUT_CYCLES > SETUP_CYCLES ? TIMEOUT_CYCLES : SETUP_CYCLES) :
        (SETTLE_CYCLES > SETUP_CYCLES ? SETTLE_CYCLES : SETUP_CYCLES);
    localparam int TW = clog2(MAXC + 1);
    localparam logic [4:0] LAST = 5'(NUM_DEV * CH_PER_DEV - 1);
    state_t        state;
    logic          stop_d, stop_edge, cont_q, load, en, expired;
    logic [TW-1:0] load_val;
    logic [4:0]    pos;
`ifdef ASW_SKIP_MASK_EN
    localparam logic [5:0] TOTAL = 6'(NUM_DEV * CH_PER_DEV);
    logic [5:0]  cand;
    logic [31:0] mask_w;
    assign mask_w = 32'(ch_mask);
`endif
    assign stop_edge = stop_flag && !stop_d;
    assign pos = {asw_addr, asw_channel};
    // Each load primes the phase being entered, so the count runs while that phase is active.
    always_comb begin
        load = state == IDLE || state == NEXT || (state == SETUP && expired) || (state == WAIT_STOP && stop_edge);
        en = state inside {SETUP, START, WAIT_STOP, SETTLE};
        load_val = state == SETUP ? TW'(TIMEOUT_CYCLES - 1) :
                   state == WAIT_STOP ? TW'(SETTLE_CYCLES - 1) : TW'(SETUP_CYCLES - 1);
    end
    asw_cycle_timer #(.W(TW)) u_timer (
        .clk(clk), .reset_n(reset_n), .load(load), .en(en), .value(load_val), .expired(expired)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            stop_d <= 1'b0;
            cont_q <= 1'b0;
            start_flag <= 1'b0;
            asw_addr <= '0;
            asw_channel <= '0;
            ch_valid <= 1'b0;
            busy <= 1'b0;
            scan_done <= 1'b0;
            timeout_err <= 1'b0;
`ifdef ASW_SKIP_MASK_EN
            cand <= '0;
`endif
        end else begin
            stop_d <= stop_flag;
            start_flag <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: if (scan_start) begin
                    cont_q <= continuous;
                    timeout_err <= 1'b0;
                    {asw_addr, asw_channel} <= '0;
                    busy <= 1'b1;
`ifdef ASW_SKIP_MASK_EN
                    cand <= '0;
                    state <= NEXT;
`else
                    state <= SETUP;
`endif
                end
                SETUP: if (scan_abort) begin
                    state <= IDLE; busy <= 1'b0; scan_done <= 1'b1;
                end else if (expired) begin
                    start_flag <= 1'b1; state <= START;
                end
                START: state <= WAIT_STOP;
                // An abort waits here for the frame to close so the I2C transfer is never cut short.
                WAIT_STOP: if (stop_edge) begin
                    if (scan_abort) begin
                        state <= IDLE; busy <= 1'b0; scan_done <= 1'b1;
                    end else state <= SETTLE;
                end else if (expired) begin
                    timeout_err <= 1'b1; state <= IDLE; busy <= 1'b0; scan_done <= 1'b1;
                end
                SETTLE: if (scan_abort) begin
                    state <= IDLE; busy <= 1'b0; scan_done <= 1'b1;
                end else if (expired) begin
                    ch_valid <= 1'b1; state <= PRESENT;
                end
                PRESENT: if (scan_abort) begin
                    ch_valid <= 1'b0; state <= IDLE; busy <= 1'b0; scan_done <= 1'b1;
                end else if (ch_ack) begin
                    ch_valid <= 1'b0; state <= NEXT;
                end
`ifdef ASW_SKIP_MASK_EN
                NEXT: if (scan_abort) begin
                    state <= IDLE; busy <= 1'b0; scan_done <= 1'b1;
                end else if (cand == TOTAL) begin
                    if (cont_q) cand <= '0;
                    else begin state <= IDLE; busy <= 1'b0; scan_done <= 1'b1; end
                end else if (mask_w[cand[4:0]]) cand <= cand + 1'b1;
                else begin
                    {asw_addr, asw_channel} <= cand[4:0];
                    cand <= cand + 1'b1;
                    state <= SETUP;
                end
`else
                NEXT: if (scan_abort || (pos == LAST && !cont_q)) begin
                    state <= IDLE; busy <= 1'b0; scan_done <= 1'b1;
                end else begin
                    {asw_addr, asw_channel} <= pos == LAST ? 5'd0 : pos + 5'd1;
                    state <= SETUP;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/asw_scan_seq.md
Name: asw_scan_seq

Overview:
- Channel-scan sequencer directly upstream of the ADG715 analog-switch writer.
- Steps through every switch channel on 1..4 ADG715 devices, addresses each with asw_addr/asw_channel, pulses start_flag, and waits for the I2C stop_flag.
- Waits a settle time, then presents the channel to the acquisition path with a valid/ack handshake before moving on.
- Supports single-pass and continuous scan.

Parameters:
- NUM_DEV, 4, number of ADG715 devices on the bus (1..4); device index equals asw_addr.
- SETUP_CYCLES, 2, cycles asw_addr/asw_channel are held stable before start_flag (minimum 2; the writer registers them one cycle late).
- SETTLE_CYCLES, 1000, clk cycles of analog settling after stop_flag (10 us at 100 MHz); minimum 1.
- TIMEOUT_CYCLES, 200000, maximum clk cycles from start_flag to stop_flag (2 ms).

Ports:
- clk  in  1  100 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- scan_start  in  1  1-cycle pulse; begins a scan when idle
- scan_abort  in  1  level; ends the scan at the next safe point
- continuous  in  1  1 = wrap and rescan forever; sampled at scan_start
- start_flag  out  1  1-cycle pulse to the switch writer
- asw_addr  out  2  device address to the switch writer
- asw_channel  out  3  channel index to the switch writer
- stop_flag  in  1  transaction-complete from the writer; rising edge is the event
- ch_valid  out  1  selected channel settled and ready for acquisition
- ch_ack  in  1  acquisition done; consumed when ch_valid && ch_ack
- busy  out  1  high in any state other than IDLE
- scan_done  out  1  1-cycle pulse at the end of a single-pass scan or an abort
- timeout_err  out  1  sticky; cleared by the next scan_start

Behaviour:
- Reset values: all outputs 0; asw_addr = 0, asw_channel = 0; state IDLE; all counters 0.
- stop_flag passes through a 1-flop edge detector. Edge = stop_flag && !stop_flag_d.
- FSM states and transitions:
  - IDLE: on scan_start, latch continuous, clear timeout_err, set dev = 0, ch = 0, go to SETUP.
  - SETUP: drive asw_addr/asw_channel and count SETUP_CYCLES; then go to START.
  - START: start_flag = 1 for exactly one cycle; load the timeout counter; go to WAIT_STOP.
  - WAIT_STOP: on a stop edge go to SETTLE.
    - If the counter reaches TIMEOUT_CYCLES, set timeout_err, pulse scan_done, and go to IDLE.
  - SETTLE: count SETTLE_CYCLES, then go to PRESENT.
  - PRESENT: ch_valid = 1 until ch_ack. The ack cycle deasserts ch_valid on the next edge; go to NEXT.
  - NEXT:
    - ch increments 0..7. After ch = 7, ch = 0 and dev increments.
    - After dev = NUM_DEV-1 and ch = 7: if continuous, wrap to dev 0 / ch 0 and go to SETUP; else pulse scan_done and go to IDLE.
    - Otherwise go to SETUP.
- Latency: scan_start to first start_flag = 1 + SETUP_CYCLES cycles. Stop edge to ch_valid = SETTLE_CYCLES + 1 cycles.
- asw_addr/asw_channel change only on the NEXT to SETUP transition. They are stable from SETUP through PRESENT.
- scan_abort:
  - Honoured only in SETUP, SETTLE, PRESENT and NEXT: go to IDLE and pulse scan_done.
  - In START/WAIT_STOP it is deferred until the stop edge (or timeout), so an I2C frame is never truncated.
- scan_start while busy is ignored.
- Stop edges outside WAIT_STOP are ignored.
- ch_ack outside PRESENT is ignored.
- The stop edge and the timeout in the same cycle: the stop edge wins.
- Asynchronous reset mid-transaction returns to IDLE immediately. The writer is reset by the same reset_n.

Optional Feature:
- Macro ASW_SKIP_MASK_EN.
- When defined:
  - Adds input ch_mask [NUM_DEV*8-1:0]; bit (dev*8+ch) = 1 skips that channel.
  - NEXT searches forward one candidate per cycle until it finds an unmasked channel.
  - An all-ones mask gives scan_done with no start_flag.
  - ch_mask is sampled live in NEXT.
- When undefined: the port is absent and every channel is visited.

Decomposition:
- Package asw_scan_pkg:
  - FSM state enum (IDLE, SETUP, START, WAIT_STOP, SETTLE, PRESENT, NEXT).
  - CH_PER_DEV = 8.
  - Counter width function clog2 for TIMEOUT_CYCLES.
- Sub-module asw_cycle_timer: one shared down-counter with load value, enable, and expired flag. It serves the SETUP, SETTLE and WAIT_STOP timing, since those phases never overlap.

Test Plan:
- NUM_DEV=1, single pass, writer model returns stop 50 cycles after start, ch_ack 3 cycles after ch_valid -> 8 start_flags with (addr 0, ch 0..7) in order, then exactly one scan_done; busy drops the same cycle.
- NUM_DEV=2, continuous=1 -> after (1,7) the next SETUP drives (0,0); no scan_done; 17th start_flag addresses (0,0).
- Stop_flag never returned, TIMEOUT_CYCLES=100 -> timeout_err set 100 cycles after start_flag, scan_done pulses; the next scan_start clears timeout_err.
- scan_abort asserted in WAIT_STOP -> no state change until the stop edge, then IDLE plus scan_done, with no ch_valid.
- Asynchronous reset_n low during SETTLE -> all outputs 0 immediately.
- With ASW_SKIP_MASK_EN, ch_mask=8'hF5 -> start_flags only for ch 1 and 3.
